// File: rtl/data_memory_stage.sv
// Data memory stage: carries each instruction through DM1/DM2/DM3, aligns stores, extends loads.
// Latency: capture edge to write-back is 3 edges (DM1 -> DM2 -> DM3); each stall cycle adds one.
// Backpressure: while a DM1 request waits for CACHE_READY, STALL_OUT holds upstream and DM1; DM2 takes bubbles.
module data_memory_stage #(
  parameter logic HIGH = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] ALU_OUT_IN,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic        CACHE_REQ,
  output logic [31:0] CACHE_ADDR,
  output logic [3:0]  CACHE_WE,
  output logic [31:0] CACHE_WDATA,
  input  logic        CACHE_READY,
  input  logic [31:0] CACHE_RDATA,
  output logic        STALL_OUT,
  output logic [31:0] RS_DATA_DM1,
  output logic [31:0] RS_DATA_DM2,
  output logic [31:0] RS_DATA_DM3,
  output logic [4:0]  RD_ADDRESS_DM1,
  output logic [4:0]  RD_ADDRESS_DM2,
  output logic [4:0]  RD_ADDRESS_DM3,
  output logic        RD_WRITE_ENABLE_DM1,
  output logic        RD_WRITE_ENABLE_DM2,
  output logic        RD_WRITE_ENABLE_DM3,
  output logic        IS_LOAD_DM1,
  output logic        IS_LOAD_DM2,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RD_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        MISALIGNED_OUT
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  // DM1 slot: raw copy of the execution-stage outputs
  logic [4:0]  dm1_rd_q, dm1_rd_d;
  logic [31:0] dm1_alu_q, dm1_alu_d;
  logic [2:0]  dm1_ld_q, dm1_ld_d;
  logic [1:0]  dm1_st_q, dm1_st_d;
  logic [31:0] dm1_sdat_q, dm1_sdat_d;
  logic        dm1_wbsel_q, dm1_wbsel_d;
  logic        dm1_we_q, dm1_we_d;

  // DM2 slot: load kind is NONE for non-loads and misaligned loads
  logic [4:0]  dm2_rd_q, dm2_rd_d;
  logic [31:0] dm2_alu_q, dm2_alu_d;
  logic [2:0]  dm2_ld_q, dm2_ld_d;
  logic        dm2_wbsel_q, dm2_wbsel_d;
  logic        dm2_we_q, dm2_we_d;
  logic        dm2_mis_q, dm2_mis_d;

  // DM3 slot: final write-back triple plus misalignment flag
  logic [4:0]  dm3_rd_q, dm3_rd_d;
  logic [31:0] dm3_data_q, dm3_data_d;
  logic        dm3_we_q, dm3_we_d;
  logic        dm3_mis_q, dm3_mis_d;

  logic        dm1_is_load;
  logic        dm1_is_store;
  logic        dm1_misaligned;
  logic        cache_req;
  logic        stall;
  logic [3:0]  cache_we;
  logic [31:0] cache_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  // DM1 decode: misalignment check, request, and lane-aligned store strobes/data
  always_comb begin
    dm1_is_load = (dm1_ld_q == LD_LB) || (dm1_ld_q == LD_LH) || (dm1_ld_q == LD_LW) ||
                  (dm1_ld_q == LD_LBU) || (dm1_ld_q == LD_LHU);
    dm1_is_store = (dm1_st_q != ST_NONE);
    dm1_misaligned = 1'b0;
    case (dm1_ld_q)
      LD_LH, LD_LHU: dm1_misaligned = dm1_alu_q[0];
      LD_LW:         dm1_misaligned = |dm1_alu_q[1:0];
      default:       ;
    endcase
    case (dm1_st_q)
      ST_SH:   if (dm1_alu_q[0]) dm1_misaligned = 1'b1;
      ST_SW:   if (|dm1_alu_q[1:0]) dm1_misaligned = 1'b1;
      default: ;
    endcase
    cache_req = (dm1_is_load | dm1_is_store) & ~dm1_misaligned;
    stall = cache_req & ~CACHE_READY;
    cache_we = 4'b0000;
    cache_wdata = 32'h0;
    case (dm1_st_q)
      ST_SB: begin
        cache_we = 4'b0001 << dm1_alu_q[1:0];
        cache_wdata = {4{dm1_sdat_q[7:0]}};
      end
      ST_SH: begin
        cache_we = 4'b0011 << dm1_alu_q[1:0];
        cache_wdata = {2{dm1_sdat_q[15:0]}};
      end
      ST_SW: begin
        cache_we = 4'b1111;
        cache_wdata = dm1_sdat_q;
      end
      default: ;
    endcase
    // Strobes only ever accompany a live request
    if (!cache_req) cache_we = 4'b0000;
  end

  // DM2 load path: pick the addressed lane of the returned word and extend it
  always_comb begin
    case (dm2_alu_q[1:0])
      2'd0:    ld_byte = CACHE_RDATA[7:0];
      2'd1:    ld_byte = CACHE_RDATA[15:8];
      2'd2:    ld_byte = CACHE_RDATA[23:16];
      default: ld_byte = CACHE_RDATA[31:24];
    endcase
    ld_half = dm2_alu_q[1] ? CACHE_RDATA[31:16] : CACHE_RDATA[15:0];
    case (dm2_ld_q)
      LD_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
      LD_LBU:  load_ext = {24'h0, ld_byte};
      LD_LHU:  load_ext = {16'h0, ld_half};
      default: load_ext = CACHE_RDATA;
    endcase
  end

  // Slot advance: DM1 holds on stall and DM2 takes a bubble; DM2->DM3 always moves
  always_comb begin
    dm1_rd_d    = dm1_rd_q;
    dm1_alu_d   = dm1_alu_q;
    dm1_ld_d    = dm1_ld_q;
    dm1_st_d    = dm1_st_q;
    dm1_sdat_d  = dm1_sdat_q;
    dm1_wbsel_d = dm1_wbsel_q;
    dm1_we_d    = dm1_we_q;
    dm2_rd_d    = 5'd0;
    dm2_alu_d   = 32'h0;
    dm2_ld_d    = LD_NONE;
    dm2_wbsel_d = 1'b0;
    dm2_we_d    = 1'b0;
    dm2_mis_d   = 1'b0;
    if (!stall) begin
      dm1_rd_d    = RD_ADDRESS_IN;
      dm1_alu_d   = ALU_OUT_IN;
      dm1_ld_d    = DATA_CACHE_LOAD_IN;
      dm1_st_d    = DATA_CACHE_STORE_IN;
      dm1_sdat_d  = DATA_CACHE_STORE_DATA_IN;
      dm1_wbsel_d = WRITE_BACK_MUX_SELECT_IN;
      dm1_we_d    = RD_WRITE_ENABLE_IN;
      dm2_rd_d    = dm1_rd_q;
      dm2_alu_d   = dm1_alu_q;
      dm2_ld_d    = (dm1_is_load && !dm1_misaligned) ? dm1_ld_q : LD_NONE;
      dm2_wbsel_d = dm1_wbsel_q & ~dm1_misaligned;
      dm2_we_d    = dm1_we_q & ~dm1_misaligned;
      dm2_mis_d   = dm1_misaligned;
    end
    dm3_rd_d   = dm2_rd_q;
    dm3_data_d = (dm2_wbsel_q && (dm2_ld_q != LD_NONE)) ? load_ext : dm2_alu_q;
    dm3_we_d   = dm2_we_q;
    dm3_mis_d  = dm2_mis_q;
  end

  // Slot registers; reset empties the whole pipeline, including any held request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dm1_rd_q    <= 5'd0;
      dm1_alu_q   <= 32'h0;
      dm1_ld_q    <= LD_NONE;
      dm1_st_q    <= ST_NONE;
      dm1_sdat_q  <= 32'h0;
      dm1_wbsel_q <= 1'b0;
      dm1_we_q    <= 1'b0;
      dm2_rd_q    <= 5'd0;
      dm2_alu_q   <= 32'h0;
      dm2_ld_q    <= LD_NONE;
      dm2_wbsel_q <= 1'b0;
      dm2_we_q    <= 1'b0;
      dm2_mis_q   <= 1'b0;
      dm3_rd_q    <= 5'd0;
      dm3_data_q  <= 32'h0;
      dm3_we_q    <= 1'b0;
      dm3_mis_q   <= 1'b0;
    end else begin
      dm1_rd_q    <= dm1_rd_d;
      dm1_alu_q   <= dm1_alu_d;
      dm1_ld_q    <= dm1_ld_d;
      dm1_st_q    <= dm1_st_d;
      dm1_sdat_q  <= dm1_sdat_d;
      dm1_wbsel_q <= dm1_wbsel_d;
      dm1_we_q    <= dm1_we_d;
      dm2_rd_q    <= dm2_rd_d;
      dm2_alu_q   <= dm2_alu_d;
      dm2_ld_q    <= dm2_ld_d;
      dm2_wbsel_q <= dm2_wbsel_d;
      dm2_we_q    <= dm2_we_d;
      dm2_mis_q   <= dm2_mis_d;
      dm3_rd_q    <= dm3_rd_d;
      dm3_data_q  <= dm3_data_d;
      dm3_we_q    <= dm3_we_d;
      dm3_mis_q   <= dm3_mis_d;
    end
  end

  assign CACHE_REQ           = cache_req;
  assign CACHE_ADDR          = {dm1_alu_q[31:2], 2'b00};
  assign CACHE_WE            = cache_we;
  assign CACHE_WDATA         = cache_wdata;
  assign STALL_OUT           = stall ? HIGH : ~HIGH;

  // Forwarding: DM1/DM2 expose the ALU result; DM3 exposes the final write-back value
  assign RS_DATA_DM1         = dm1_alu_q;
  assign RS_DATA_DM2         = dm2_alu_q;
  assign RS_DATA_DM3         = dm3_data_q;
  assign RD_ADDRESS_DM1      = dm1_rd_q;
  assign RD_ADDRESS_DM2      = dm2_rd_q;
  assign RD_ADDRESS_DM3      = dm3_rd_q;
  assign RD_WRITE_ENABLE_DM1 = dm1_we_q & ~dm1_misaligned;
  assign RD_WRITE_ENABLE_DM2 = dm2_we_q;
  assign RD_WRITE_ENABLE_DM3 = dm3_we_q;
  assign IS_LOAD_DM1         = dm1_is_load ? HIGH : ~HIGH;
  assign IS_LOAD_DM2         = (dm2_ld_q != LD_NONE) ? HIGH : ~HIGH;

  assign RD_ADDRESS_OUT      = dm3_rd_q;
  assign RD_DATA_OUT         = dm3_data_q;
  assign RD_WRITE_ENABLE_OUT = dm3_we_q;
  assign MISALIGNED_OUT      = dm3_mis_q ? HIGH : ~HIGH;

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: directed cases from the feature list plus randomized traffic.
// Memory behaviour is modelled with a sparse word array; results are predicted per instruction.
// Cache readiness is randomized to exercise stalls and bubbles.
module tb_data_memory_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] ALU_OUT_IN;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA_IN;
  logic        WRITE_BACK_MUX_SELECT_IN;
  logic        RD_WRITE_ENABLE_IN;
  logic        CACHE_REQ;
  logic [31:0] CACHE_ADDR;
  logic [3:0]  CACHE_WE;
  logic [31:0] CACHE_WDATA;
  logic        CACHE_READY;
  logic [31:0] CACHE_RDATA;
  logic        STALL_OUT;
  logic [31:0] RS_DATA_DM1, RS_DATA_DM2, RS_DATA_DM3;
  logic [4:0]  RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3;
  logic        RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2, RD_WRITE_ENABLE_DM3;
  logic        IS_LOAD_DM1, IS_LOAD_DM2;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [31:0] RD_DATA_OUT;
  logic        RD_WRITE_ENABLE_OUT;
  logic        MISALIGNED_OUT;

  data_memory_stage #(.HIGH(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .ALU_OUT_IN(ALU_OUT_IN),
    .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
    .DATA_CACHE_STORE_DATA_IN(DATA_CACHE_STORE_DATA_IN),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .CACHE_REQ(CACHE_REQ), .CACHE_ADDR(CACHE_ADDR), .CACHE_WE(CACHE_WE), .CACHE_WDATA(CACHE_WDATA),
    .CACHE_READY(CACHE_READY), .CACHE_RDATA(CACHE_RDATA), .STALL_OUT(STALL_OUT),
    .RS_DATA_DM1(RS_DATA_DM1), .RS_DATA_DM2(RS_DATA_DM2), .RS_DATA_DM3(RS_DATA_DM3),
    .RD_ADDRESS_DM1(RD_ADDRESS_DM1), .RD_ADDRESS_DM2(RD_ADDRESS_DM2), .RD_ADDRESS_DM3(RD_ADDRESS_DM3),
    .RD_WRITE_ENABLE_DM1(RD_WRITE_ENABLE_DM1), .RD_WRITE_ENABLE_DM2(RD_WRITE_ENABLE_DM2),
    .RD_WRITE_ENABLE_DM3(RD_WRITE_ENABLE_DM3),
    .IS_LOAD_DM1(IS_LOAD_DM1), .IS_LOAD_DM2(IS_LOAD_DM2),
    .RD_ADDRESS_OUT(RD_ADDRESS_OUT), .RD_DATA_OUT(RD_DATA_OUT),
    .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT), .MISALIGNED_OUT(MISALIGNED_OUT)
  );

  always #5 CLK = ~CLK;

  // One instruction as presented by the execution stage
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] sd;
    logic        wbsel;
    logic        we;
  } ins_t;

  // What an instruction is expected to look like once past DM1
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] fwd;
    logic [31:0] res;
    logic        we;
    logic        isld;
    logic        mis;
  } slot_t;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  ins_t  m1, cur;
  slot_t m2, m3;
  logic [31:0] mem [int unsigned];
  logic        pend_vld;
  logic [31:0] pend_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    int unsigned idx;
    idx = addr >> 2;
    if (mem.exists(idx)) return mem[idx];
    return (idx * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic void mem_wr(input logic [31:0] addr, input logic [3:0] stb, input logic [31:0] dat);
    logic [31:0] w;
    int unsigned idx;
    idx = addr >> 2;
    w = mem_rd(addr);
    for (int b = 0; b < 4; b++) if (stb[b]) w[8*b +: 8] = dat[8*b +: 8];
    mem[idx] = w;
  endfunction

  function automatic logic f_is_load(input logic [2:0] ld);
    return (ld >= 3'd1) && (ld <= 3'd5);
  endfunction

  function automatic logic f_mis(input ins_t i);
    logic half, word;
    half = (i.ld == 3'd2) || (i.ld == 3'd5) || (i.st == 2'd2);
    word = (i.ld == 3'd3) || (i.st == 2'd3);
    return (half && i.alu[0]) || (word && (i.alu[1:0] != 2'b00));
  endfunction

  function automatic logic f_req(input ins_t i);
    return (f_is_load(i.ld) || (i.st != 2'd0)) && !f_mis(i);
  endfunction

  function automatic logic [3:0] f_strobe(input ins_t i);
    logic [3:0] s;
    s = 4'b0000;
    if (f_req(i)) begin
      if (i.st == 2'd1) s = 4'b0001;
      if (i.st == 2'd2) s = 4'b0011;
      if (i.st == 2'd3) s = 4'b1111;
      else s = s << i.alu[1:0];
    end
    return s;
  endfunction

  function automatic logic [31:0] f_wdata(input ins_t i);
    case (i.st)
      2'd1:    return {4{i.sd[7:0]}};
      2'd2:    return {2{i.sd[15:0]}};
      2'd3:    return i.sd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_ext(input logic [31:0] word, input logic [2:0] ld, input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> (8 * int'(lane));
    case (ld)
      3'd1:    return {{24{sh[7]}}, sh[7:0]};
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic ins_t mk(input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] ld,
                              input logic [1:0] st, input logic [31:0] sd, input logic wbsel, input logic we);
    ins_t i;
    i.rd = rd; i.alu = alu; i.ld = ld; i.st = st; i.sd = sd; i.wbsel = wbsel; i.we = we;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int k, v;
    i = '0;
    i.rd = 5'($urandom_range(0, 31));
    i.sd = $urandom;
    k = $urandom_range(0, 2);
    if (k == 0) begin
      v = $urandom_range(0, 5);
      i.alu = $urandom;
      i.ld = (v == 4) ? 3'd6 : ((v == 5) ? 3'd7 : 3'd0);
      i.we = 1'($urandom_range(0, 1));
    end else if (k == 1) begin
      i.alu = 32'($urandom_range(0, 1023));
      i.ld = 3'($urandom_range(1, 5));
      i.wbsel = 1'b1;
      i.we = 1'b1;
    end else begin
      i.alu = 32'($urandom_range(0, 1023));
      i.st = 2'($urandom_range(1, 3));
    end
    return i;
  endfunction

  task automatic drive(input ins_t i);
    RD_ADDRESS_IN = i.rd;
    ALU_OUT_IN = i.alu;
    DATA_CACHE_LOAD_IN = i.ld;
    DATA_CACHE_STORE_IN = i.st;
    DATA_CACHE_STORE_DATA_IN = i.sd;
    WRITE_BACK_MUX_SELECT_IN = i.wbsel;
    RD_WRITE_ENABLE_IN = i.we;
  endtask

  task automatic compare();
    chk("cache_req", 32'(CACHE_REQ), 32'(f_req(m1)));
    chk("cache_addr", CACHE_ADDR, {m1.alu[31:2], 2'b00});
    chk("cache_we", 32'(CACHE_WE), 32'(f_strobe(m1)));
    if (f_req(m1) && (m1.st != 2'd0)) chk("cache_wdata", CACHE_WDATA, f_wdata(m1));
    chk("stall", 32'(STALL_OUT), 32'(f_req(m1) && !CACHE_READY));
    chk("rs_dm1", RS_DATA_DM1, m1.alu);
    chk("rd_dm1", 32'(RD_ADDRESS_DM1), 32'(m1.rd));
    chk("we_dm1", 32'(RD_WRITE_ENABLE_DM1), 32'(m1.we && !f_mis(m1)));
    chk("isld_dm1", 32'(IS_LOAD_DM1), 32'(f_is_load(m1.ld)));
    chk("rs_dm2", RS_DATA_DM2, m2.fwd);
    chk("rd_dm2", 32'(RD_ADDRESS_DM2), 32'(m2.rd));
    chk("we_dm2", 32'(RD_WRITE_ENABLE_DM2), 32'(m2.we));
    chk("isld_dm2", 32'(IS_LOAD_DM2), 32'(m2.isld));
    chk("rs_dm3", RS_DATA_DM3, m3.res);
    chk("rd_dm3", 32'(RD_ADDRESS_DM3), 32'(m3.rd));
    chk("we_dm3", 32'(RD_WRITE_ENABLE_DM3), 32'(m3.we));
    chk("rd_addr_out", 32'(RD_ADDRESS_OUT), 32'(m3.rd));
    chk("rd_data_out", RD_DATA_OUT, m3.res);
    chk("rd_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'(m3.we));
    chk("misaligned_out", 32'(MISALIGNED_OUT), 32'(m3.mis));
  endtask

  // One clock: drive at the falling edge, check, predict, then let the rising edge happen
  task automatic step(input ins_t nxt, input logic rdy, output logic taken);
    logic  stall_m;
    slot_t n2;
    @(negedge CLK);
    CACHE_RDATA = pend_vld ? pend_word : $urandom;
    CACHE_READY = rdy;
    stall_m = f_req(m1) && !rdy;
    taken = !stall_m;
    if (!stall_m) cur = nxt;
    drive(cur);
    #1;
    compare();
    if (STALL_OUT === 1'b1) stall_cnt++;
    if (CACHE_REQ === 1'b1) req_cnt++;
    n2 = '0;
    if (!stall_m) begin
      n2.rd = m1.rd;
      n2.fwd = m1.alu;
      n2.mis = f_mis(m1);
      n2.we = m1.we && !n2.mis;
      n2.isld = f_is_load(m1.ld) && !n2.mis;
      n2.res = (m1.wbsel && n2.isld) ? f_ext(mem_rd(m1.alu), m1.ld, m1.alu[1:0]) : m1.alu;
    end
    pend_vld = 1'b0;
    if (f_req(m1) && rdy) begin
      if (m1.st != 2'd0) mem_wr(m1.alu, f_strobe(m1), f_wdata(m1));
      else begin
        pend_vld = 1'b1;
        pend_word = mem_rd(m1.alu);
      end
    end
    @(posedge CLK);
    m3 = m2;
    m2 = n2;
    if (!stall_m) m1 = cur;
    #1;
  endtask

  initial begin
    logic tk;
    int   s0, r0;
    ins_t nx;
    RST_N = 1'b0;
    CACHE_READY = 1'b1;
    CACHE_RDATA = 32'h0;
    cur = '0;
    m1 = '0; m2 = '0; m3 = '0;
    pend_vld = 1'b0;
    pend_word = 32'h0;
    drive(cur);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_cache_req", 32'(CACHE_REQ), 32'h0);
    chk("rst_cache_we", 32'(CACHE_WE), 32'h0);
    chk("rst_stall", 32'(STALL_OUT), 32'h0);
    chk("rst_misaligned", 32'(MISALIGNED_OUT), 32'h0);
    chk("rst_rd_data", RD_DATA_OUT, 32'h0);
    chk("rst_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Plain ALU result flows to write-back after three edges
    r0 = req_cnt;
    step(mk(5'd5, 32'h1234, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1), 1'b1, tk);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("alu_rd_data", RD_DATA_OUT, 32'h0000_1234);
    chk("alu_rd_addr", 32'(RD_ADDRESS_OUT), 32'd5);
    chk("alu_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
    chk("alu_no_req", 32'(req_cnt - r0), 32'd0);

    // SB to byte 3 of word 0x100
    step(mk(5'd0, 32'h103, 3'd0, 2'd1, 32'hAABBCCDD, 1'b0, 1'b0), 1'b1, tk);
    chk("sb_req", 32'(CACHE_REQ), 32'd1);
    chk("sb_addr", CACHE_ADDR, 32'h0000_0100);
    chk("sb_we", 32'(CACHE_WE), 32'h8);
    chk("sb_wdata", CACHE_WDATA, 32'hDDDD_DDDD);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("sb_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);

    // Byte/half loads with sign and zero extension
    mem[32'h40] = 32'h00F1_0000;
    step(mk(5'd6, 32'h102, 3'd1, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("lb_data", RD_DATA_OUT, 32'hFFFF_FFF1);
    step(mk(5'd6, 32'h102, 3'd4, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("lbu_data", RD_DATA_OUT, 32'h0000_00F1);
    mem[32'h40] = 32'h8001_0000;
    step(mk(5'd6, 32'h102, 3'd2, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("lh_data", RD_DATA_OUT, 32'hFFFF_8001);

    // LW held for three not-ready cycles
    mem[32'h80] = 32'hCAFE_F00D;
    s0 = stall_cnt;
    step(mk(5'd7, 32'h200, 3'd3, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    repeat (3) step('0, 1'b0, tk);
    chk("lw_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    step('0, 1'b1, tk);
    step('0, 1'b1, tk);
    chk("lw_stall_data", RD_DATA_OUT, 32'hCAFE_F00D);
    chk("lw_stall_rd", 32'(RD_ADDRESS_OUT), 32'd7);

    // Misaligned LW: no request, flagged at DM3, write suppressed
    r0 = req_cnt;
    step(mk(5'd9, 32'h201, 3'd3, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    step('0, 1'b1, tk);
    chk("mis_not_yet", 32'(MISALIGNED_OUT), 32'd0);
    step('0, 1'b1, tk);
    chk("mis_flag", 32'(MISALIGNED_OUT), 32'd1);
    chk("mis_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("mis_no_req", 32'(req_cnt - r0), 32'd0);

    // Asynchronous reset in the middle of a stall
    step(mk(5'd3, 32'hDEAD_0000, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1), 1'b1, tk);
    step(mk(5'd4, 32'h300, 3'd3, 2'd0, 32'h0, 1'b1, 1'b1), 1'b1, tk);
    @(negedge CLK);
    CACHE_READY = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(STALL_OUT), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_stall", 32'(STALL_OUT), 32'd0);
    chk("arst_req", 32'(CACHE_REQ), 32'd0);
    chk("arst_we", 32'(CACHE_WE), 32'd0);
    chk("arst_rs_dm1", RS_DATA_DM1, 32'h0);
    chk("arst_rs_dm2", RS_DATA_DM2, 32'h0);
    chk("arst_we_dm2", 32'(RD_WRITE_ENABLE_DM2), 32'd0);
    chk("arst_isld_dm1", 32'(IS_LOAD_DM1), 32'd0);
    chk("arst_rd_data", RD_DATA_OUT, 32'h0);
    m1 = '0; m2 = '0; m3 = '0;
    pend_vld = 1'b0;
    cur = '0;
    drive(cur);
    CACHE_READY = 1'b1;
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    r0 = req_cnt;
    repeat (3) step('0, 1'b1, tk);
    chk("post_rst_no_req", 32'(req_cnt - r0), 32'd0);
    chk("post_rst_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);

    // Randomized traffic with random cache readiness
    nx = rand_ins();
    for (int c = 0; c < 3000; c++) begin
      step(nx, ($urandom_range(0, 3) != 0), tk);
      if (tk) nx = rand_ins();
    end
    repeat (4) step('0, 1'b1, tk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
